// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM state encoding and word geometry for the boot-time program loader.
package imem_loader_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_ADDR_STEP = 4;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_CHECK, S_DONE} state_e;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream, instruction-memory write port and core control of the loader.
interface imem_loader_if;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_reset;
  logic        done;
  logic        chk_err;
  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, mem_write, mem_addr, mem_wdata, core_reset, done, chk_err
  );
  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, mem_write, mem_addr, mem_wdata, core_reset, done, chk_err
  );
endinterface

// File: rtl/imem_byte_assembler.sv
// imem_byte_assembler: shifts stream bytes MSB-first into a 32-bit word and flags the completing byte.
module imem_byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        take_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);
  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;
  always_comb begin
    word_d = clear_i ? '0 : take_i ? {word_q[23:0], byte_i} : word_q;
    cnt_d  = clear_i ? '0 : take_i ? cnt_q + 2'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end
  assign word_o      = word_q;
  // high on the take that lands the fourth byte, so the FSM can leave LOAD on that same edge
  assign word_full_o = take_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a big-endian program image into instruction memory, holding the core in reset until done.
// Optional IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte that gates core release.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          NUM_WORDS = 128,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst,
  imem_loader_if.slave  bus_io
);
  state_e      state_q;
  logic        byte_ready_q, mem_write_q, core_reset_q, done_q;
  logic [31:0] mem_addr_q, word_cnt_q, word;
  logic        take, take_word, start_ok, word_full, last_word;
  assign take      = bus_io.byte_valid && byte_ready_q;
  assign take_word = take && (state_q == S_LOAD);
  assign start_ok  = bus_io.start && (state_q == S_IDLE || state_q == S_DONE);
  assign last_word = word_cnt_q == 32'(NUM_WORDS - 1);
  imem_byte_assembler u_asm (
    .clk(clk), .rst(rst), .clear_i(start_ok), .take_i(take_word),
    .byte_i(bus_io.byte_in), .word_o(word), .word_full_o(word_full)
  );
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q;
  logic       chk_err_q, mismatch;
  assign mismatch = bus_io.byte_in != xor_q;
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      xor_q     <= '0;
      chk_err_q <= 1'b0;
    end else begin
      if (take_word) xor_q <= xor_q ^ bus_io.byte_in;
      if (take && state_q == S_CHECK) chk_err_q <= mismatch;
    end
  end
  assign bus_io.chk_err = chk_err_q;
`else
  assign bus_io.chk_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      byte_ready_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= BASE_ADDR;
      word_cnt_q   <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
    end else if (start_ok) begin
      state_q      <= S_LOAD;
      byte_ready_q <= 1'b1;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= BASE_ADDR;
      word_cnt_q   <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: if (word_full) begin
          state_q      <= S_WRITE;
          byte_ready_q <= 1'b0;
          mem_write_q  <= 1'b1;
        end
        S_WRITE: begin
          mem_write_q <= 1'b0;
          word_cnt_q  <= word_cnt_q + 32'd1;
          mem_addr_q  <= mem_addr_q + 32'(WORD_ADDR_STEP);
          if (!last_word) begin
            state_q      <= S_LOAD;
            byte_ready_q <= 1'b1;
          end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_q      <= S_CHECK;
            byte_ready_q <= 1'b1;
`else
            state_q      <= S_DONE;
            core_reset_q <= 1'b0;
            done_q       <= 1'b1;
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        // a bad checksum still finishes the load but keeps the core parked in reset
        S_CHECK: if (take) begin
          state_q      <= S_DONE;
          byte_ready_q <= 1'b0;
          done_q       <= 1'b1;
          core_reset_q <= mismatch;
        end
`endif
        default: ;
      endcase
    end
  end
  assign bus_io.byte_ready = byte_ready_q;
  assign bus_io.mem_write  = mem_write_q;
  assign bus_io.mem_addr   = mem_addr_q;
  assign bus_io.mem_wdata  = word;
  assign bus_io.core_reset = core_reset_q;
  assign bus_io.done       = done_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed, table-driven checks of the program loader with a two-word image at a wrapping base.
module tb_imem_loader;
  localparam logic [31:0] BASE = 32'hFFFF_FFFC;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int LAT = 11;
  localparam int NB  = 9;
`else
  localparam int LAT = 10;
  localparam int NB  = 8;
`endif
  typedef struct {
    int          gap;
    logic [7:0]  b [8];
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  imem_loader_if bus();
  imem_loader #(.NUM_WORDS(2), .BASE_ADDR(BASE)) dut (.clk(clk), .rst(rst), .bus_io(bus));
  int total = 0, bad = 0, cyc = 0, wr_total = 0, done_rise = -1, gap_bad = 0, s_cyc = 0;
  logic done_prev = 1'b0;
  logic [31:0] addr_log [16];
  logic [31:0] data_log [16];
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bus.mem_write) begin
      addr_log[wr_total % 16] = bus.mem_addr;
      data_log[wr_total % 16] = bus.mem_wdata;
      wr_total++;
    end
    if (bus.done && !done_prev) done_rise = cyc;
    done_prev = bus.done;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic pulse_start;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    s_cyc = cyc;
  endtask
  task automatic send_bytes(input logic [7:0] bs [10], input int n, input int gap);
    int t;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      for (int g = 0; g < gap; g++) begin
        bus.byte_valid = 1'b0;
        if (i % 4 != 0 && !bus.byte_ready) gap_bad++;
        @(negedge clk);
      end
      bus.byte_valid = 1'b1;
      bus.byte_in    = bs[i];
      t = 0;
      while (!bus.byte_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: byte %0d not accepted within 100 cycles", i);
        return;
      end
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask
  function automatic logic [7:0] xsum(input logic [7:0] b [8]);
    logic [7:0] x = '0;
    for (int i = 0; i < 8; i++) x ^= b[i];
    return x;
  endfunction
  vec_t vecs [4];
  logic [7:0] bs [10];
  int w0, seen;
  initial begin
    bus.start = 1'b0; bus.byte_valid = 1'b0; bus.byte_in = 8'h00;
    vecs[0].gap = 0; vecs[0].b = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h3C, 8'h09, 8'h00, 8'h10};
    vecs[0].w0 = 32'h2008_0005; vecs[0].w1 = 32'h3C09_0010;
    vecs[1].gap = 3; vecs[1].b = vecs[0].b; vecs[1].w0 = 32'h2008_0005; vecs[1].w1 = 32'h3C09_0010;
    vecs[2].gap = 1; vecs[2].b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2].w0 = 32'hDEAD_BEEF; vecs[2].w1 = 32'h0000_0000;
    vecs[3].gap = 0; vecs[3].b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04};
    vecs[3].w0 = 32'hFFFF_FFFF; vecs[3].w1 = 32'h0102_0304;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.byte_ready, 0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_addr", bus.mem_addr, BASE);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_core_reset", bus.core_reset, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_chk_err", bus.chk_err, 0);
    rst = 1'b0;
    w0 = wr_total; seen = 0;
    bus.byte_valid = 1'b1; bus.byte_in = 8'hAA;
    repeat (10) begin
      @(negedge clk);
      if (bus.byte_ready) seen++;
    end
    bus.byte_valid = 1'b0;
    chk("idle_ready_cycles", seen, 0);
    chk("idle_writes", wr_total - w0, 0);
    chk("idle_core_reset", bus.core_reset, 1);
    foreach (vecs[k]) begin
      w0 = wr_total; gap_bad = 0;
      pulse_start;
      chk($sformatf("v%0d_start_done", k), bus.done, 0);
      chk($sformatf("v%0d_start_core_reset", k), bus.core_reset, 1);
      for (int i = 0; i < 8; i++) bs[i] = vecs[k].b[i];
      bs[8] = xsum(vecs[k].b);
      send_bytes(bs, NB, vecs[k].gap);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_writes", k), wr_total - w0, 2);
      chk($sformatf("v%0d_addr0", k), addr_log[w0 % 16], BASE);
      chk($sformatf("v%0d_data0", k), data_log[w0 % 16], vecs[k].w0);
      chk($sformatf("v%0d_addr1", k), addr_log[(w0 + 1) % 16], 32'h0000_0000);
      chk($sformatf("v%0d_data1", k), data_log[(w0 + 1) % 16], vecs[k].w1);
      chk($sformatf("v%0d_done", k), bus.done, 1);
      chk($sformatf("v%0d_core_reset", k), bus.core_reset, 0);
      chk($sformatf("v%0d_chk_err", k), bus.chk_err, 0);
      if (vecs[k].gap == 0) chk($sformatf("v%0d_done_latency", k), done_rise - s_cyc, LAT);
      else chk($sformatf("v%0d_gap_ready_drops", k), gap_bad, 0);
    end
    w0 = wr_total; seen = 0;
    bus.byte_valid = 1'b1; bus.byte_in = 8'h55;
    repeat (5) begin
      @(negedge clk);
      if (bus.byte_ready) seen++;
    end
    bus.byte_valid = 1'b0;
    chk("done_ignore_ready", seen, 0);
    chk("done_ignore_writes", wr_total - w0, 0);
    chk("done_ignore_done", bus.done, 1);
    w0 = wr_total;
    pulse_start;
    for (int i = 0; i < 8; i++) bs[i] = vecs[0].b[i];
    send_bytes(bs, 6, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_writes", wr_total - w0, 1);
    chk("midrst_data0", data_log[w0 % 16], 32'h2008_0005);
    chk("midrst_ready", bus.byte_ready, 0);
    chk("midrst_core_reset", bus.core_reset, 1);
    chk("midrst_done", bus.done, 0);
    chk("midrst_addr", bus.mem_addr, BASE);
    chk("midrst_wdata", bus.mem_wdata, 0);
    w0 = wr_total;
    pulse_start;
    bs[8] = xsum(vecs[0].b);
    send_bytes(bs, NB, 0);
    repeat (2) @(negedge clk);
    chk("restart_writes", wr_total - w0, 2);
    chk("restart_addr0", addr_log[w0 % 16], BASE);
    chk("restart_data0", data_log[w0 % 16], 32'h2008_0005);
    chk("restart_done", bus.done, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start;
    bs = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hFF, 8'h00};
    send_bytes(bs, 9, 0);
    repeat (2) @(negedge clk);
    chk("bad_sum_chk_err", bus.chk_err, 1);
    chk("bad_sum_done", bus.done, 1);
    chk("bad_sum_core_reset", bus.core_reset, 1);
    pulse_start;
    chk("bad_sum_clear_on_start", bus.chk_err, 0);
    bs[8] = 8'h08;
    send_bytes(bs, 9, 0);
    repeat (2) @(negedge clk);
    chk("good_sum_chk_err", bus.chk_err, 0);
    chk("good_sum_core_reset", bus.core_reset, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
